fetch_queue: RTL
================

# fetch_queue

Instruction fetch stage with a prefetch buffer. It sits directly upstream of decode. It issues sequential word fetches to instruction memory over a variable-latency req/ack handshake and buffers the returned words in a DEPTH-entry FIFO. It presents the FIFO head to decode and flushes and redirects on a jump from decode or a taken branch from execute.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- Stall  in  1  decode holding; head not consumed
- Jump_IDM1  in  1  jump redirect from decode
- JumpTgt_IDM1  in  32  full byte address of jump target
- BranchTaken_EXM1  in  1  taken-branch redirect from execute
- BranchTgt_EXM1  in  32  full byte address of branch target
- ImemReq  out  1  fetch request, registered
- ImemAddr  out  32  fetch byte address, registered, word aligned
- ImemAck  in  1  request completes this cycle; ImemData valid
- ImemData  in  32  instruction word
- FetchValid_IF  out  1  FIFO head valid
- FetchData_IF  out  32  FIFO head instruction
- FetchPc_IF  out  32  FIFO head address

## Operation
- FIFO: DEPTH entries of {pc, instr}; read/write pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Enqueue: ImemAck high in WAIT → {ImemAddr, ImemData} written at the tail.
- Dequeue: FetchValid_IF && !Stall.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Enqueue and dequeue are both legal when full, provided a request is outstanding.
- Redirect: BranchTaken_EXM1 wins over Jump_IDM1, because execute is older. Target = BranchTgt_EXM1 if taken, else JumpTgt_IDM1.
  - On redirect, the FIFO is flushed (pointers and count reset to 0) and fpc ← target.
  - Flush wins over any same-cycle enqueue or dequeue.
  - Redirect applies regardless of Stall.
- Only one request is outstanding at a time. ImemReq and ImemAddr stay stable until ImemAck; a request is never withdrawn.
- State machine:
  - IDLE (ImemReq=0)
    - Go to WAIT with ImemAddr ← fpc when count < DEPTH.
    - A redirect in the same cycle uses the target as ImemAddr.
  - WAIT (ImemReq=1)
    - Ack, no redirect: enqueue. fpc ← ImemAddr+4.
      - Stay in WAIT with ImemAddr ← ImemAddr+4 if the post-update count < DEPTH.
      - Otherwise go to IDLE.
    - Ack with redirect: data discarded. Stay in WAIT with ImemAddr ← target.
    - Redirect without ack: go to DROP, record the target in fpc.
  - DROP (ImemReq=1, stale request in flight)
    - Ack: data discarded. Go to WAIT with ImemAddr ← fpc.
    - A further redirect updates fpc and stays in DROP. If it coincides with ack, the newest target is used.
- Address arithmetic is 32-bit and wraps modulo 2^32; bits [1:0] are always 0.
- Targets are taken as given and are not realigned.

## Timing
- Reset (asynchronous on reset=0):
  - ImemReq=0, ImemAddr=0, state IDLE, fpc=RESET_PC.
  - FIFO empty, FetchValid_IF=0, FetchData_IF=0, FetchPc_IF=0.
- First cycle after reset release: state IDLE with count 0, so ImemReq=1 with ImemAddr=RESET_PC at the first posedge.
- A zero-wait memory (ack in the first req cycle) sustains 1 instruction per cycle, with ImemReq held continuously high.
- Ack in cycle N → entry visible on FetchValid_IF, FetchData_IF and FetchPc_IF in cycle N+1. There is no bypass.
- Head outputs are read from registered storage and are stable while Stall is high.
- Redirect sampled in cycle N:
  - FetchValid_IF=0 in N+1.
  - ImemAddr=target in N+1 if no request was in flight, or if the in-flight request acked in N.
- With a stale request in flight, the target request follows one cycle after the stale ack.
- Reset asserted mid-request: state is reset immediately. The memory is expected to abandon the request; a late ack while in IDLE is ignored.
- Full FIFO with Stall high: no new request issues. Issue resumes the cycle after the first dequeue.

## Test plan
- Reset release, zero-wait memory returning ImemData=addr^32'hFFFF_FFFF, Stall=0:
  - ImemAddr goes 0,4,8,C… on consecutive cycles.
  - FetchPc_IF follows one cycle behind, with FetchData_IF matching.
- Stall held high with zero-wait memory:
  - Exactly 4 acks, then ImemReq=0, FetchPc_IF stuck at 0.
  - Release Stall → ImemReq=1 the next cycle at address 0x10.
- Memory with 3-cycle ack latency, Jump_IDM1=1 with JumpTgt_IDM1=0x100 one cycle after a request to 0x8:
  - The 0x8 ack is discarded and the FIFO is empty.
  - The next request is 0x100; the first FetchPc_IF is 0x100.
- BranchTaken_EXM1 (tgt 0x200) and Jump_IDM1 (tgt 0x300) in the same cycle as an ack:
  - Ack data dropped; the next ImemAddr is 0x200.
  - No 0x300 fetch ever appears.
- Wrap-around: RESET_PC=32'hFFFF_FFF8, zero-wait memory → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset pulsed low while in WAIT with 2 FIFO entries:
  - FetchValid_IF=0 and ImemReq=0 immediately, asynchronously to clk.
  - Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch into a DEPTH-entry FIFO.
// Ports: clk/reset, Stall/Jump/Branch redirects, Imem req/ack, head out.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Jump_IDM1,
    input  logic [31:0] JumpTgt_IDM1,
    input  logic        BranchTaken_EXM1,
    input  logic [31:0] BranchTgt_EXM1,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic        FetchValid_IF,
    output logic [31:0] FetchData_IF,
    output logic [31:0] FetchPc_IF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] pc_mem  [DEPTH];
    logic [31:0] ins_mem [DEPTH];

    logic        redir;
    logic [31:0] tgt;
    logic        enq;
    logic        deq;

    // Execute is older than decode, so its branch wins.
    assign redir = BranchTaken_EXM1 | Jump_IDM1;
    assign tgt   = BranchTaken_EXM1 ? BranchTgt_EXM1 : JumpTgt_IDM1;
    assign enq   = (state_q == S_WAIT) && ImemAck && !redir;
    assign deq   = FetchValid_IF && !Stall;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (redir) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (enq) wr_d = wr_q + AW'(1);
            if (deq) rd_d = rd_q + AW'(1);
            if (enq && !deq)
                cnt_d = cnt_q + CW'(1);
            else if (!enq && deq)
                cnt_d = cnt_q - CW'(1);
        end
    end

    // Issue decisions use the post-update count so a dequeue this
    // cycle lets a request go out on the next edge.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_WAIT: begin
                if (ImemAck) begin
                    if (redir) begin
                        fpc_d  = tgt;
                        addr_d = tgt;
                    end else begin
                        fpc_d = addr_q + 32'd4;
                        if (cnt_d < FULL)
                            addr_d = addr_q + 32'd4;
                        else
                            state_d = S_IDLE;
                    end
                end else if (redir) begin
                    fpc_d   = tgt;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (redir) fpc_d = tgt;
                if (ImemAck) begin
                    state_d = S_WAIT;
                    addr_d  = redir ? tgt : fpc_q;
                end
            end
            default: begin
                if (redir) begin
                    fpc_d   = tgt;
                    addr_d  = tgt;
                    state_d = S_WAIT;
                end else if (cnt_d < FULL) begin
                    addr_d  = fpc_q;
                    state_d = S_WAIT;
                end
            end
        endcase
        req_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            fpc_q   <= RESET_PC;
            addr_q  <= '0;
            req_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_q]  <= addr_q;
            ins_mem[wr_q] <= ImemData;
        end
    end

    assign ImemReq       = req_q;
    assign ImemAddr      = addr_q;
    assign FetchValid_IF = (cnt_q != '0);
    // Empty head reads as zero so stale entries never leak out.
    assign FetchData_IF  = FetchValid_IF ? ins_mem[rd_q] : '0;
    assign FetchPc_IF    = FetchValid_IF ? pc_mem[rd_q] : '0;

endmodule
